// File: rtl/axis_frame_source.sv
// Purpose: captures strobed samples into a FIFO and emits them as an AXI4-Stream master with framed tlast.
// Latency: a sample written into an empty FIFO is presented on m_axis_tvalid one cycle after its write edge.
// Backpressure: m_axis_tready low holds the presented beat; samples arriving while full are dropped (sticky overflow).
//
// Ports:
//   aclk, resetn              clock (rising edge) and asynchronous active-low reset
//   sample_data, sample_ce    input sample and its one-cycle strobe
//   m_axis_tdata/tlast/tvalid/tready   AXI4-Stream master, tlast on every frame_length-th beat
//   fifo_level                entries held, including the output register
//   overflow, clear_overflow  sticky drop flag and its synchronous clear
module axis_frame_source #(
  parameter int frame_length      = 32,
  parameter int data_width        = 16,
  parameter int fifo_depth_width  = 6,
  parameter int frame_count_width = 5
) (
  input  logic                      aclk,
  input  logic                      resetn,
  input  logic [data_width-1:0]     sample_data,
  input  logic                      sample_ce,
  output logic [data_width-1:0]     m_axis_tdata,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [fifo_depth_width:0] fifo_level,
  output logic                      overflow,
  input  logic                      clear_overflow
);

  localparam int Depth = 2 ** fifo_depth_width;
  localparam logic [fifo_depth_width:0]    LevelFull = (fifo_depth_width + 1)'(Depth);
  localparam logic [fifo_depth_width:0]    LevelOne  = (fifo_depth_width + 1)'(1);
  localparam logic [fifo_depth_width-1:0]  PtrOne    = fifo_depth_width'(1);
  localparam logic [frame_count_width-1:0] CntLast   = frame_count_width'(frame_length - 1);
  localparam logic [frame_count_width-1:0] CntOne    = frame_count_width'(1);

  logic [data_width-1:0]        mem_q [Depth];
  logic [fifo_depth_width-1:0]  wr_ptr_q, wr_ptr_d;
  logic [fifo_depth_width-1:0]  rd_ptr_q, rd_ptr_d;
  logic [fifo_depth_width:0]    level_q, level_d;
  logic [fifo_depth_width:0]    mem_cnt;
  logic [frame_count_width-1:0] cnt_q, cnt_d;
  logic [data_width-1:0]        tdata_q, tdata_d;
  logic                         tlast_q, tlast_d;
  logic                         tvalid_q, tvalid_d;
  logic                         overflow_q, overflow_d;

  logic handshake, full, accept, drop, load;

  always_comb begin
    handshake = tvalid_q & m_axis_tready;
    full      = (level_q == LevelFull);
    // A full FIFO still takes a sample when a beat leaves in the same cycle.
    accept    = sample_ce & (~full | handshake);
    drop      = sample_ce & ~accept;
    // Entries still in storage, i.e. not yet moved into the output register.
    mem_cnt   = level_q - {{fifo_depth_width{1'b0}}, tvalid_q};
    // Refill the output register only from storage: this gives the one-cycle
    // fall-through latency and keeps tready off every output path.
    load      = (mem_cnt != '0) & (~tvalid_q | handshake);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (handshake) begin
      cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CntOne;
    end

    level_d = level_q;
    case ({accept, handshake})
      2'b10:   level_d = level_q + LevelOne;
      2'b01:   level_d = level_q - LevelOne;
      default: level_d = level_q;
    endcase

    wr_ptr_d = accept ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = load   ? rd_ptr_q + PtrOne : rd_ptr_q;

    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    if (load) begin
      tvalid_d = 1'b1;
      tdata_d  = mem_q[rd_ptr_q];
      // The new beat's index is the counter after this cycle's handshake.
      tlast_d  = (cnt_d == CntLast);
    end else if (handshake) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end

    // A drop in the same cycle as a clear keeps the flag set.
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  // Storage needs no reset: the pointers and level define what is valid.
  always_ff @(posedge aclk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= sample_data;
    end
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      cnt_q      <= '0;
      tdata_q    <= '0;
      tlast_q    <= 1'b0;
      tvalid_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      cnt_q      <= cnt_d;
      tdata_q    <= tdata_d;
      tlast_q    <= tlast_d;
      tvalid_q   <= tvalid_d;
      overflow_q <= overflow_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;
  assign fifo_level    = level_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_axis_frame_source.sv
// Purpose: scoreboard bench for axis_frame_source; stimulus pushes expected beats, a monitor pops and compares.
// Latency: checks the one-cycle fall-through after a strobe into an empty FIFO.
// Backpressure: drives held-low and random tready, checks stall stability, overflow and full-with-handshake.
module tb_axis_frame_source;

  logic        aclk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] sample_data = '0;
  logic        sample_ce = 1'b0;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic [6:0]  fifo_level;
  logic        overflow;
  logic        clear_overflow = 1'b0;

  axis_frame_source #(
    .frame_length(32), .data_width(16), .fifo_depth_width(6), .frame_count_width(5)
  ) dut (
    .aclk(aclk), .resetn(resetn),
    .sample_data(sample_data), .sample_ce(sample_ce),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .fifo_level(fifo_level), .overflow(overflow), .clear_overflow(clear_overflow)
  );

  always #5 aclk = ~aclk;

  int tests = 0;
  int errors = 0;
  int exp_idx = 0;      // index of the next accepted sample within the stream
  int beats = 0;        // beats seen by the monitor
  logic [16:0] exp_q[$]; // {tlast, tdata}
  bit rand_done;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] d);
    exp_q.push_back({(exp_idx % 32) == 31, d});
    exp_idx++;
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Caller sits just after a rising edge; the strobe is captured on the next edge.
  task automatic strobe(input logic [15:0] d, input bit accepted);
    sample_ce = 1'b1;
    sample_data = d;
    if (accepted) push_exp(d);
    step();
    sample_ce = 1'b0;
  endtask

  task automatic drain(input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge aclk);
      if (exp_q.size() == 0 && !m_axis_tvalid) done = 1;
    end
    chk("drain_left", exp_q.size(), 0);
    chk("drain_done", int'(done), 1);
    step();
  endtask

  // Monitor: samples on the falling edge, so tvalid & tready seen here is the
  // handshake on the next rising edge.
  initial begin
    logic        stall_prev = 0;
    logic [15:0] prev_data = '0;
    logic        prev_last = 0;
    logic [16:0] e;
    forever begin
      @(negedge aclk);
      if (!resetn) begin
        stall_prev = 0;
      end else begin
        if (stall_prev) begin
          chk("stall_tvalid", int'(m_axis_tvalid), 1);
          chk("stall_tdata", int'(m_axis_tdata), int'(prev_data));
          chk("stall_tlast", int'(m_axis_tlast), int'(prev_last));
        end
        if (m_axis_tvalid && m_axis_tready) begin
          beats++;
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", int'(m_axis_tdata), -1);
          end else begin
            e = exp_q.pop_front();
            chk("beat_tdata", int'(m_axis_tdata), int'(e[15:0]));
            chk("beat_tlast", int'(m_axis_tlast), int'(e[16]));
          end
        end
        stall_prev = m_axis_tvalid && !m_axis_tready;
        prev_data = m_axis_tdata;
        prev_last = m_axis_tlast;
      end
    end
  end

  initial begin
    // T1: reset held with strobes toggling
    for (int i = 0; i < 6; i++) begin
      sample_ce = i[0];
      sample_data = 16'(i);
      @(negedge aclk);
      chk("rst_tvalid", int'(m_axis_tvalid), 0);
      chk("rst_tlast", int'(m_axis_tlast), 0);
      chk("rst_level", int'(fifo_level), 0);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_tdata", int'(m_axis_tdata), 0);
    end
    sample_ce = 1'b0;
    step();
    resetn = 1'b1;
    repeat (4) step();
    @(negedge aclk);
    chk("idle_tvalid", int'(m_axis_tvalid), 0);
    chk("idle_level", int'(fifo_level), 0);
    step();

    // T2: single frame, one strobe every 4 cycles, latency checked per strobe
    m_axis_tready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      strobe(16'(i), 1);
      @(negedge aclk);
      chk("lat_edgeN", int'(m_axis_tvalid), 0);
      @(negedge aclk);
      chk("lat_edgeN1", int'(m_axis_tvalid), 1);
      step();
      step();
    end
    drain(20);
    chk("t2_overflow", int'(overflow), 0);
    chk("t2_level", int'(fifo_level), 0);
    chk("t2_beats", beats, 32);

    // T3: fill with tready low; the 65th sample is lost
    m_axis_tready = 1'b0;
    for (int i = 0; i < 65; i++) strobe(16'(i), i < 64);
    @(negedge aclk);
    chk("t3_level", int'(fifo_level), 64);
    chk("t3_overflow", int'(overflow), 1);
    step();
    m_axis_tready = 1'b1;
    drain(200);
    chk("t3_beats", beats, 96);
    chk("t3_overflow_sticky", int'(overflow), 1);
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    @(negedge aclk);
    chk("t3_cleared", int'(overflow), 0);
    step();

    // T4: random backpressure, 96 samples
    rand_done = 0;
    fork
      begin
        for (int i = 0; i < 96; i++) begin
          strobe(16'(1000 + i), 1);
          step();
          step();
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          m_axis_tready = 1'($urandom_range(0, 1));
          step();
        end
      end
    join
    m_axis_tready = 1'b1;
    drain(300);
    chk("t4_overflow", int'(overflow), 0);
    chk("t4_beats", beats, 192);

    // T5: full FIFO with a write and a handshake in the same cycle
    m_axis_tready = 1'b0;
    for (int i = 0; i < 64; i++) strobe(16'(100 + i), 1);
    @(negedge aclk);
    chk("t5_full_level", int'(fifo_level), 64);
    step();
    m_axis_tready = 1'b1;
    strobe(16'(200), 1);
    m_axis_tready = 1'b0;
    @(negedge aclk);
    chk("t5_level_held", int'(fifo_level), 64);
    chk("t5_no_overflow", int'(overflow), 0);
    step();
    clear_overflow = 1'b1;
    strobe(16'(300), 0);
    clear_overflow = 1'b0;
    @(negedge aclk);
    chk("t5_set_wins", int'(overflow), 1);
    chk("t5_level_drop", int'(fifo_level), 64);
    step();
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    @(negedge aclk);
    chk("t5_clear", int'(overflow), 0);
    step();
    m_axis_tready = 1'b1;
    drain(200);

    // T6: reset ten beats into a frame, then a full fresh frame
    while ((exp_idx % 32) != 10) strobe(16'(500 + exp_idx), 1);
    drain(50);
    resetn = 1'b0;
    exp_q.delete();
    exp_idx = 0;
    step();
    step();
    resetn = 1'b1;
    step();
    beats = 0;
    for (int i = 0; i < 32; i++) begin
      strobe(16'(700 + i), 1);
      step();
    end
    drain(50);
    chk("t6_beats", beats, 32);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
